// File: rtl/mem_io_unit.sv
// Memory-mapped word RAM plus input-port and output-port registers.
// The top of the address space holds the ports: input ports first, then
// output ports. Everything below the ports is RAM.
//
// Handshake: a request is taken on every rising edge where rd_en is 1.
// There is no back-pressure. rd_valid is 1 for exactly one cycle, one edge
// after the request, with the matching word on data_out. data_out holds its
// last value whenever rd_valid is 0.
module mem_io_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [DATA_W/8-1:0]       byte_en,
  input  logic                      write_en,
  input  logic                      rd_en,
  input  logic [NUM_IN-1:0]         in_en,
  output logic [DATA_W-1:0]         data_out,
  output logic                      rd_valid,
  output logic [NUM_OUT*DATA_W-1:0] output_port,
  output logic                      wr_err
);

  localparam int NB       = DATA_W / 8;
  localparam int IO_BASE  = (2 ** ADDR_W) - NUM_IN - NUM_OUT;
  localparam int OUT_BASE = IO_BASE + NUM_IN;
  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);

  // RAM is deliberately left without a reset so it maps onto plain memory.
  logic [DATA_W-1:0] ram [IO_BASE];
  logic [DATA_W-1:0] in_q [NUM_IN];
  logic [DATA_W-1:0] out_q [NUM_OUT];

  logic [DATA_W-1:0] in_next [NUM_IN];
  logic [DATA_W-1:0] out_next [NUM_OUT];
  logic [NUM_IN-1:0]  in_hit;
  logic [NUM_OUT-1:0] out_hit;
  logic               is_ram;
  logic               do_write;
  logic [DATA_W-1:0]  ram_new;
  logic [DATA_W-1:0]  rd_word;
  logic               wr_err_next;

  // Replace only the enabled byte lanes of a word with data_in.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] din,
                                               input logic [NB-1:0]     be);
    logic [DATA_W-1:0] w;
    w = old;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) w[b*8 +: 8] = din[b*8 +: 8];
    end
    return w;
  endfunction

  // Address decode into the RAM range and one-hot port hits.
  always_comb begin
    is_ram  = (addr < IO_BASE_A);
    in_hit  = '0;
    out_hit = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_hit[i] = (addr == ADDR_W'(IO_BASE + i));
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      out_hit[k] = (addr == ADDR_W'(OUT_BASE + k));
    end
  end

  // A write with no lanes enabled is a no-op everywhere, including errors.
  assign do_write = write_en && (|byte_en);

  // Post-update values of every location; reads see these (write-first).
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      in_next[i] = in_en[i] ? data_in : in_q[i];
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      out_next[k] = (do_write && out_hit[k]) ? merge(out_q[k], data_in, byte_en) : out_q[k];
    end
    ram_new     = (do_write && is_ram) ? merge(ram[addr], data_in, byte_en) : ram[addr];
    wr_err_next = do_write && (|in_hit);
  end

  // Select the read word from whichever region the address falls in.
  always_comb begin
    rd_word = ram_new;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_hit[i]) rd_word = in_next[i];
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      if (out_hit[k]) rd_word = out_next[k];
    end
  end

  // RAM byte-lane write; no reset on the array.
  always_ff @(posedge clk) begin
    if (write_en && is_ram) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) ram[addr][b*8 +: 8] <= data_in[b*8 +: 8];
      end
    end
  end

  // Port registers, read pipeline and error pulse with async clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_IN; i++)  in_q[i]  <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IN; i++)  in_q[i]  <= in_next[i];
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= out_next[k];
      if (rd_en) data_out <= rd_word;
      rd_valid <= rd_en;
      wr_err   <= wr_err_next;
    end
  end

  // Flatten the output-port registers onto the packed port bus.
  always_comb begin
    output_port = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      output_port[k*DATA_W +: DATA_W] = out_q[k];
    end
  end

endmodule

// File: tb/tb_mem_io_unit.sv
// Bench for mem_io_unit: a default-parameter instance checked against an
// address-indexed memory model, plus a small instance with ADDR_W=6,
// NUM_IN=3, NUM_OUT=2 checked with directed constants.
module tb_mem_io_unit;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (defaults) ----------------
  logic [7:0]  a_addr = '0;
  logic [31:0] a_data_in = '0;
  logic [3:0]  a_byte_en = '0;
  logic        a_write_en = 1'b0;
  logic        a_rd_en = 1'b0;
  logic [1:0]  a_in_en = '0;
  logic [31:0] a_data_out;
  logic        a_rd_valid;
  logic [31:0] a_output_port;
  logic        a_wr_err;

  mem_io_unit dut_a (
    .clk(clk), .rst(rst), .addr(a_addr), .data_in(a_data_in),
    .byte_en(a_byte_en), .write_en(a_write_en), .rd_en(a_rd_en),
    .in_en(a_in_en), .data_out(a_data_out), .rd_valid(a_rd_valid),
    .output_port(a_output_port), .wr_err(a_wr_err)
  );

  // ---------------- instance B (small map, IO_BASE=0x3B) ----------------
  logic [5:0]  b_addr = '0;
  logic [31:0] b_data_in = '0;
  logic [3:0]  b_byte_en = '0;
  logic        b_write_en = 1'b0;
  logic        b_rd_en = 1'b0;
  logic [2:0]  b_in_en = '0;
  logic [31:0] b_data_out;
  logic        b_rd_valid;
  logic [63:0] b_output_port;
  logic        b_wr_err;

  mem_io_unit #(.ADDR_W(6), .DATA_W(32), .NUM_IN(3), .NUM_OUT(2)) dut_b (
    .clk(clk), .rst(rst), .addr(b_addr), .data_in(b_data_in),
    .byte_en(b_byte_en), .write_en(b_write_en), .rd_en(b_rd_en),
    .in_en(b_in_en), .data_out(b_data_out), .rd_valid(b_rd_valid),
    .output_port(b_output_port), .wr_err(b_wr_err)
  );

  // ---------------- reference model for A ----------------
  // Whole 256-word address space as one array; 253/254 are the input
  // ports, 255 is the output port.
  logic [31:0] mem_a [256];
  logic [31:0] ea_dout  = '0;
  logic        ea_valid = 1'b0;
  logic        ea_err   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock of instance A: drive, update the model, then check after the edge.
  task automatic cyc_a(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic we, input logic re, input logic [1:0] ine);
    a_addr = a; a_data_in = d; a_byte_en = be;
    a_write_en = we; a_rd_en = re; a_in_en = ine;
    ea_err = 1'b0;
    if (we && be != 4'h0) begin
      if (a == 8'd253 || a == 8'd254) ea_err = 1'b1;
      else for (int b = 0; b < 4; b++) if (be[b]) mem_a[a][8*b +: 8] = d[8*b +: 8];
    end
    for (int i = 0; i < 2; i++) if (ine[i]) mem_a[253 + i] = d;
    ea_valid = re;
    if (re) ea_dout = mem_a[a];
    @(posedge clk); #1;
    chk("a_rd_valid", {63'd0, a_rd_valid}, {63'd0, ea_valid});
    chk("a_data_out", {32'd0, a_data_out}, {32'd0, ea_dout});
    chk("a_wr_err", {63'd0, a_wr_err}, {63'd0, ea_err});
    chk("a_output_port", {32'd0, a_output_port}, {32'd0, mem_a[255]});
    a_write_en = 1'b0; a_rd_en = 1'b0; a_in_en = '0; a_byte_en = '0;
  endtask

  task automatic cyc_b(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic we, input logic re, input logic [2:0] ine);
    b_addr = a; b_data_in = d; b_byte_en = be;
    b_write_en = we; b_rd_en = re; b_in_en = ine;
    @(posedge clk); #1;
    b_write_en = 1'b0; b_rd_en = 1'b0; b_in_en = '0; b_byte_en = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 32'h0;
    #12;
    chk("rst_a_data_out", {32'd0, a_data_out}, 64'd0);
    chk("rst_a_rd_valid", {63'd0, a_rd_valid}, 64'd0);
    chk("rst_a_output_port", {32'd0, a_output_port}, 64'd0);
    chk("rst_b_output_port", b_output_port, 64'd0);
    rst = 1'b1;

    // full-word write then read at 0x00
    cyc_a(8'h00, 32'h12345678, 4'hF, 1, 0, 2'b00);
    cyc_a(8'h00, 32'h0, 4'h0, 0, 1, 2'b00);
    chk("rd_0x00_const", {32'd0, a_data_out}, 64'h12345678);
    // byte-lane merge at 0x40
    cyc_a(8'h40, 32'h11111111, 4'hF, 1, 0, 2'b00);
    cyc_a(8'h40, 32'hAABBCCDD, 4'h5, 1, 0, 2'b00);
    cyc_a(8'h40, 32'h0, 4'h0, 0, 1, 2'b00);
    chk("merge_0x40_const", {32'd0, a_data_out}, 64'h11BB11DD);
    // input port loads
    cyc_a(8'h00, 32'hDEADBEEF, 4'h0, 0, 0, 2'b01);
    cyc_a(8'h00, 32'hCAFEBABE, 4'h0, 0, 0, 2'b10);
    cyc_a(8'hFD, 32'h0, 4'h0, 0, 1, 2'b00);
    chk("in0_const", {32'd0, a_data_out}, 64'hDEADBEEF);
    cyc_a(8'hFE, 32'h0, 4'h0, 0, 1, 2'b00);
    chk("in1_const", {32'd0, a_data_out}, 64'hCAFEBABE);
    // output port write, illegal write to input port
    cyc_a(8'hFF, 32'hAABBCCDD, 4'hF, 1, 0, 2'b00);
    chk("out0_const", {32'd0, a_output_port}, 64'hAABBCCDD);
    cyc_a(8'hFE, 32'h0BAD0BAD, 4'hF, 1, 0, 2'b00);
    chk("wr_err_pulse", {63'd0, a_wr_err}, 64'd1);
    cyc_a(8'hFE, 32'h0, 4'h0, 0, 1, 2'b00);
    chk("wr_err_one_cycle", {63'd0, a_wr_err}, 64'd0);
    chk("in1_unchanged", {32'd0, a_data_out}, 64'hCAFEBABE);
    // write-first and back-to-back reads
    cyc_a(8'h10, 32'h10101010, 4'hF, 1, 0, 2'b00);
    cyc_a(8'h80, 32'h33333333, 4'hF, 1, 1, 2'b00);
    chk("wfirst_0x80", {32'd0, a_data_out}, 64'h33333333);
    cyc_a(8'h10, 32'h0, 4'h0, 0, 1, 2'b00);
    cyc_a(8'h40, 32'h0, 4'h0, 0, 1, 2'b00);
    cyc_a(8'h80, 32'h0, 4'h0, 0, 1, 2'b00);
    // byte_en=0 writes are silent no-ops
    cyc_a(8'hFE, 32'hFFFFFFFF, 4'h0, 1, 0, 2'b00);
    cyc_a(8'h40, 32'hFFFFFFFF, 4'h0, 1, 1, 2'b00);
    // partial write to output port read back same cycle; in_en with read
    cyc_a(8'hFF, 32'h00990000, 4'h4, 1, 1, 2'b00);
    cyc_a(8'hFD, 32'h5A5A5A5A, 4'hF, 1, 1, 2'b11);
    cyc_a(8'h00, 32'h0, 4'h0, 0, 0, 2'b00);

    // instance B directed: IO_BASE 0x3B, in 0x3B..0x3D, out 0x3E..0x3F
    cyc_b(6'h3E, 32'h01020304, 4'hF, 1, 0, 3'b000);
    cyc_b(6'h3F, 32'hA0B0C0D0, 4'hF, 1, 0, 3'b000);
    chk("b_output_port", b_output_port, 64'hA0B0C0D0_01020304);
    cyc_b(6'h00, 32'h55AA55AA, 4'h0, 0, 0, 3'b101);
    cyc_b(6'h3B, 32'h0, 4'h0, 0, 1, 3'b000);
    chk("b_in0", {32'd0, b_data_out}, 64'h55AA55AA);
    chk("b_rd_valid", {63'd0, b_rd_valid}, 64'd1);
    cyc_b(6'h3C, 32'h0, 4'h0, 0, 1, 3'b000);
    chk("b_in1", {32'd0, b_data_out}, 64'h0);
    cyc_b(6'h3D, 32'h0, 4'h0, 0, 1, 3'b000);
    chk("b_in2", {32'd0, b_data_out}, 64'h55AA55AA);
    cyc_b(6'h3C, 32'h12121212, 4'hF, 1, 0, 3'b000);
    chk("b_wr_err", {63'd0, b_wr_err}, 64'd1);
    cyc_b(6'h3A, 32'h77665544, 4'hF, 1, 0, 3'b000);
    chk("b_wr_err_clear", {63'd0, b_wr_err}, 64'd0);
    chk("b_rd_valid_idle", {63'd0, b_rd_valid}, 64'd0);
    cyc_b(6'h3A, 32'h0, 4'h0, 0, 1, 3'b000);
    chk("b_ram_top", {32'd0, b_data_out}, 64'h77665544);
    cyc_b(6'h3E, 32'h0, 4'h0, 0, 1, 3'b000);
    chk("b_out0_read", {32'd0, b_data_out}, 64'h01020304);

    // fill A's RAM so every random read has a defined expectation
    for (int i = 0; i < 253; i++) cyc_a(8'(i), $urandom, 4'hF, 1, 0, 2'b00);
    // randomized traffic over the whole map
    for (int n = 0; n < 400; n++) begin
      cyc_a(8'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    cyc_a(8'hFF, 32'hC0FFEE00, 4'hF, 1, 0, 2'b11);

    // reset with a read in flight
    a_addr = 8'h40; a_rd_en = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_a_data_out", {32'd0, a_data_out}, 64'd0);
    chk("mid_rst_a_rd_valid", {63'd0, a_rd_valid}, 64'd0);
    chk("mid_rst_a_wr_err", {63'd0, a_wr_err}, 64'd0);
    chk("mid_rst_a_output_port", {32'd0, a_output_port}, 64'd0);
    chk("mid_rst_b_output_port", b_output_port, 64'd0);
    chk("mid_rst_b_data_out", {32'd0, b_data_out}, 64'd0);
    a_rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_a[253] = '0; mem_a[254] = '0; mem_a[255] = '0;
    ea_dout = '0;
    cyc_a(8'h00, 32'h0, 4'h0, 0, 0, 2'b00);
    cyc_a(8'hFD, 32'h0, 4'h0, 0, 1, 2'b00);
    cyc_b(6'h3D, 32'h0, 4'h0, 0, 1, 3'b000);
    chk("post_rst_b_in2", {32'd0, b_data_out}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
